// File: rtl/mips_reg_file.sv
// mips_reg_file: 2-read / 1-write general-purpose register file for the
// multicycle MIPS datapath. After every reset a sweep FSM zeroes the storage
// one entry per cycle, so the array itself needs no reset and can map to RAM.
// Optional feature macro: REG_FILE_BYPASS_EN (write-first read ports when
// defined, read-first when undefined).
module mips_reg_file #(
   parameter int WIDTH      = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  jal_en,
   input  logic [WIDTH-1:0]      jal_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr0,
   output logic [WIDTH-1:0]      rd_data0,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   output logic [WIDTH-1:0]      rd_data1
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   // cnt is one bit wider than an address so reaching NUM_REGS is representable
   localparam logic [ADDR_WIDTH:0]   CNT_END   = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LINK_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [WIDTH-1:0]      mem_wdata;

   logic [WIDTH-1:0]      mem_q [NUM_REGS];
   logic [WIDTH-1:0]      rd_data0_q, rd_data1_q;

   // Next-state logic and the single shared write port (sweep or user write)
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (state_q == ST_CLEAR) begin
         if (cnt_q == CNT_END) begin
            state_d = ST_RUN;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
         end
      end else begin
         // link write wins; a concurrent wr_en is dropped
         if (jal_en) begin
            mem_we    = 1'b1;
            mem_waddr = LINK_ADDR;
            mem_wdata = jal_data;
         end else if (wr_en && (wr_addr != '0)) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
         end
      end
   end

   // Sweep FSM state and counter; reset restarts the sweep from entry 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage array: no reset, cleared by the sweep instead
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   logic user_we;
   logic hit0, hit1;

   assign user_we = mem_we && (state_q == ST_RUN);
   assign hit0    = user_we && (mem_waddr == rd_addr0);
   assign hit1    = user_we && (mem_waddr == rd_addr1);

   // Registered reads, write-first: a same-cycle write is forwarded
   always_ff @(posedge clk) begin
      if (rst || (state_q != ST_RUN)) begin
         rd_data0_q <= '0;
         rd_data1_q <= '0;
      end else begin
         rd_data0_q <= (rd_addr0 == '0) ? '0 : (hit0 ? mem_wdata : mem_q[rd_addr0]);
         rd_data1_q <= (rd_addr1 == '0) ? '0 : (hit1 ? mem_wdata : mem_q[rd_addr1]);
      end
   end
`else
   // Registered reads, read-first: a same-cycle write is not yet visible
   always_ff @(posedge clk) begin
      if (rst || (state_q != ST_RUN)) begin
         rd_data0_q <= '0;
         rd_data1_q <= '0;
      end else begin
         rd_data0_q <= (rd_addr0 == '0) ? '0 : mem_q[rd_addr0];
         rd_data1_q <= (rd_addr1 == '0) ? '0 : mem_q[rd_addr1];
      end
   end
`endif

   assign ready    = (state_q == ST_RUN);
   assign rd_data0 = rd_data0_q;
   assign rd_data1 = rd_data1_q;

endmodule

// File: tb/tb_mips_reg_file.sv
// Testbench for mips_reg_file: behavioural register-file model checked every
// cycle, plus directed literal checks for the named scenarios.
module tb_mips_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        jal_en;
   logic [31:0] jal_data;
   logic [4:0]  rd_addr0;
   logic [31:0] rd_data0;
   logic [4:0]  rd_addr1;
   logic [31:0] rd_data1;

   int n_chk = 0;
   int n_err = 0;

   mips_reg_file dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .jal_en   (jal_en),
      .jal_data (jal_data),
      .rd_addr0 (rd_addr0),
      .rd_data0 (rd_data0),
      .rd_addr1 (rd_addr1),
      .rd_data1 (rd_data1)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] model_mem [32];
   bit          m_valid = 1'b0;
   int          m_since = 0;
   bit          m_ready = 1'b0;
   logic [31:0] m_rd0 = '0;
   logic [31:0] m_rd1 = '0;

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
      if (jal_en && a == 5'd31) return jal_data;
      if (!jal_en && wr_en && wr_addr == a) return wr_data;
`endif
      return model_mem[a];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1;
         m_since <= 0;
         m_ready <= 1'b0;
         m_rd0   <= '0;
         m_rd1   <= '0;
         foreach (model_mem[i]) model_mem[i] <= '0;
      end else if (m_valid) begin
         m_since <= m_since + 1;
         m_ready <= (m_since + 1 >= 33);
         if (m_ready) begin
            m_rd0 <= mread(rd_addr0);
            m_rd1 <= mread(rd_addr1);
            if (jal_en) model_mem[31] <= jal_data;
            else if (wr_en && wr_addr != 5'd0) model_mem[wr_addr] <= wr_data;
         end else begin
            m_rd0 <= '0;
            m_rd1 <= '0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_ready", {31'd0, ready}, {31'd0, m_ready});
         chk("model_rd0", rd_data0, m_rd0);
         chk("model_rd1", rd_data1, m_rd1);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      jal_en = 1'b0; jal_data = '0;
      rd_addr0 = '0; rd_addr1 = '0;
   endtask

   task automatic wait_ready(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic pulse_rst_and_sweep(input string nm);
      int n;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_ready(n);
      chk(nm, n, 32'd33);
      @(negedge clk);
   endtask

   task automatic fill_index();
      for (int r = 1; r < 32; r++) begin
         wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'(r);
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic check_all_zero(input string nm);
      for (int r = 1; r < 32; r++) begin
         rd_addr0 = 5'(r);
         rd_addr1 = 5'(32 - r);
         @(negedge clk);
         chk(nm, rd_data0 | rd_data1, 32'd0);
      end
   endtask

   initial begin
      int n;
      logic [31:0] coll_exp;
      idle();
      rst = 1'b1;
      // reset sweep with write inputs held active
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_rd0", rd_data0, 32'd0);
      chk("reset_rd1", rd_data1, 32'd0);
      rst = 1'b0;
      wait_ready(n);
      chk("sweep_len_initial", n, 32'd33);
      wr_en = 1'b0;
      rd_addr0 = 5'd5;
      @(negedge clk);
      chk("r5_after_sweep", rd_data0, 32'd0);

      // basic write then read on both ports
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      wr_en = 1'b0; rd_addr0 = 5'd3; rd_addr1 = 5'd3;
      @(negedge clk);
      chk("r3_port0", rd_data0, 32'hDEAD_BEEF);
      chk("r3_port1", rd_data1, 32'hDEAD_BEEF);

      // r0 protection
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
      @(negedge clk);
      wr_en = 1'b0; rd_addr0 = 5'd0; rd_addr1 = 5'd0;
      @(negedge clk);
      chk("r0_read", rd_data0 | rd_data1, 32'd0);

      // JAL priority over wr_en
      jal_en = 1'b1; jal_data = 32'h0040_0008;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA_AAAA;
      @(negedge clk);
      jal_en = 1'b0; wr_en = 1'b0; rd_addr0 = 5'd31; rd_addr1 = 5'd7;
      @(negedge clk);
      chk("jal_r31", rd_data0, 32'h0040_0008);
      chk("jal_r7_unchanged", rd_data1, 32'd0);

      // same-address collision
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1111_1111;
      @(negedge clk);
      wr_data = 32'h2222_2222; rd_addr0 = 5'd9;
      @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
      coll_exp = 32'h2222_2222;
`else
      coll_exp = 32'h1111_1111;
`endif
      chk("collision_r9", rd_data0, coll_exp);
      wr_en = 1'b0;
      @(negedge clk);
      chk("r9_next_cycle", rd_data0, 32'h2222_2222);

      // randomized traffic, collisions biased in, rare resets
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 249) == 0);
         wr_en    = $urandom_range(0, 1) == 1;
         wr_addr  = 5'($urandom_range(0, 31));
         wr_data  = $urandom;
         jal_en   = ($urandom_range(0, 7) == 0);
         jal_data = $urandom;
         rd_addr0 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rd_addr1 = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         @(negedge clk);
      end
      idle();
      rst = 1'b0;
      pulse_rst_and_sweep("sweep_len_after_random");

      // mid-sweep reset at cnt=10
      fill_index();
      rd_addr0 = 5'd10; rd_addr1 = 5'd31;
      @(negedge clk);
      chk("fill_r10", rd_data0, 32'd10);
      chk("fill_r31", rd_data1, 32'd31);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_sweep_not_ready", {31'd0, ready}, 32'd0);
      pulse_rst_and_sweep("sweep_len_mid_sweep");
      check_all_zero("zero_after_mid_sweep");

      // reset while in RUN
      fill_index();
      rd_addr0 = 5'd17;
      @(negedge clk);
      chk("fill_r17", rd_data0, 32'd17);
      pulse_rst_and_sweep("sweep_len_mid_run");
      check_all_zero("zero_after_mid_run");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
